// File: rtl/fifo_ochobits_cond_if.sv
// fifo_ochobits_cond_if
//   Bundles the push/pop handshake, data and status flags of one
//   fifo_ochobits_cond lane. clk and reset_L are not part of the bundle.
//   master : the demux lane / consumer side (drives push, data_in, pop)
//   slave  : the FIFO side (drives data_out, valid_out, count and flags)
//   Parameters must match the ones given to the attached FIFO instance.
interface fifo_ochobits_cond_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, count, full, empty,
               almost_full, almost_empty, error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, count, full, empty,
               almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_ochobits_cond.sv
// fifo_ochobits_cond
//   Eight-bit synchronous FIFO placed after each output lane of the 1-to-2
//   demux. Words are written on push, read in order on pop through a
//   registered output; count and threshold flags let the consumer throttle
//   the demux.
// Ports:
//   clk      : rising-edge clock
//   reset_L  : asynchronous active-low reset
//   bus      : fifo_ochobits_cond_if.slave
//              push/data_in  write strobe and data
//              pop           read request
//              data_out/valid_out registered read data and its qualifier
//              count         occupancy 0..DEPTH
//              full/empty/almost_full/almost_empty decoded from count
//              error         overflow/underflow indication
// Build option:
//   FIFO_ERROR_STICKY_EN defined   -> error is set on the first fault and held
//                                     until reset_L is asserted
//   FIFO_ERROR_STICKY_EN undefined -> error is a one-cycle pulse after each
//                                     faulting edge
module fifo_ochobits_cond #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int UMBRAL_ALTO = 3,
    parameter int UMBRAL_BAJO = 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    fifo_ochobits_cond_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_ALTO  = (ADDR_WIDTH+1)'(UMBRAL_ALTO);
    localparam logic [ADDR_WIDTH:0] C_BAJO  = (ADDR_WIDTH+1)'(UMBRAL_BAJO);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_fault;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // A push while full is still accepted when a pop frees a slot in the
    // same cycle; a pop is never served from the incoming word (no bypass).
    assign w_pop_acc  = bus.pop && !w_empty;
    assign w_push_acc = bus.push && (!w_full || bus.pop);
    assign w_fault    = (bus.push && w_full && !bus.pop) || (bus.pop && w_empty);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_valid_out <= w_pop_acc;

            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - (ADDR_WIDTH+1)'(1);
            end

`ifdef FIFO_ERROR_STICKY_EN
            r_error <= r_error || w_fault;
`else
            r_error <= w_fault;
`endif
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.valid_out    = r_valid_out;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= C_ALTO);
    assign bus.almost_empty = (r_count <= C_BAJO);
    assign bus.error        = r_error;
endmodule

// File: tb/tb_fifo_ochobits_cond.sv
module tb_fifo_ochobits_cond;
`ifdef FIFO_ERROR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fifo_ochobits_cond_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut_if ();

    fifo_ochobits_cond #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .ADDR_WIDTH (2),
        .UMBRAL_ALTO(3),
        .UMBRAL_BAJO(1)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (dut_if.slave)
    );

    // Observed status: {count[2:0], full, empty, almost_full, almost_empty, valid_out, error}
    function automatic logic [8:0] st();
        return {dut_if.count, dut_if.full, dut_if.empty, dut_if.almost_full,
                dut_if.almost_empty, dut_if.valid_out, dut_if.error};
    endfunction

    // Expected status from an expected occupancy (DEPTH=4, ALTO=3, BAJO=1).
    function automatic logic [8:0] mk(input int c, input logic v, input logic e);
        logic [2:0] cc;
        cc = 3'(c);
        return {cc, (c == 4), (c == 0), (c >= 3), (c <= 1), v, e};
    endfunction

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic cyc(input logic p, input logic [7:0] d, input logic q);
        dut_if.push    = p;
        dut_if.data_in = d;
        dut_if.pop     = q;
        @(posedge clk);
        #1;
        dut_if.push = 1'b0;
        dut_if.pop  = 1'b0;
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        #12;
        e = mk(0, 0, 0);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL reset_init got=%b exp=%b", st(), e); end
        reset_L = 1'b1;
        cyc(1, 8'h3C, 0);
        cyc(1, 8'h4D, 0);
        cyc(0, 8'h00, 1);
        checks++;
        if (dut_if.data_out !== 8'h3C) begin failures++; $display("FAIL reset_predata got=%h exp=3c", dut_if.data_out); end
        // Reset in the middle of a push burst.
        dut_if.push = 1'b1;
        dut_if.data_in = 8'h5E;
        #2;
        reset_L = 1'b0;
        #1;
        e = mk(0, 0, 0);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL reset_mid got=%b exp=%b", st(), e); end
        checks++;
        if (dut_if.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", dut_if.data_out); end
        dut_if.push = 1'b0;
        #2;
        reset_L = 1'b1;
        cyc(1, 8'h6F, 0);
        e = mk(1, 0, 0);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL reset_firstpush got=%b exp=%b", st(), e); end
        cyc(0, 8'h00, 1);
        checks++;
        if (dut_if.data_out !== 8'h6F) begin failures++; $display("FAIL reset_firstpop got=%h exp=6f", dut_if.data_out); end
    endtask

    task automatic test_order();
        logic [7:0] w [3];
        logic [8:0] e;
        w[0] = 8'hA1; w[1] = 8'hB2; w[2] = 8'hC3;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1, w[i], 0);
            e = mk(i + 1, 0, 0);
            checks++;
            if (st() !== e) begin failures++; $display("FAIL order_push%0d got=%b exp=%b", i, st(), e); end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1);
            e = mk(2 - i, 1, 0);
            checks++;
            if (st() !== e) begin failures++; $display("FAIL order_popst%0d got=%b exp=%b", i, st(), e); end
            checks++;
            if (dut_if.data_out !== w[i]) begin failures++; $display("FAIL order_pop%0d got=%h exp=%h", i, dut_if.data_out, w[i]); end
        end
        cyc(0, 8'h00, 0);
        e = mk(0, 0, 0);
        checks++;
        if (st() !== e || dut_if.data_out !== 8'hC3) begin
            failures++; $display("FAIL order_hold got=%b/%h exp=%b/c3", st(), dut_if.data_out, e);
        end
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp_w [4];
        logic [8:0] e;
        exp_w[0] = 8'h03; exp_w[1] = 8'h04; exp_w[2] = 8'h55; exp_w[3] = 8'h66;
        // Pointers sit at 3 after test_order, so this fill wraps them.
        for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0);
        e = mk(4, 0, 0);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL fill_full got=%b exp=%b", st(), e); end
        cyc(1, 8'hEE, 0);
        e = mk(4, 0, 1);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL fill_overflow got=%b exp=%b", st(), e); end
        cyc(0, 8'h00, 1);
        e = mk(3, 1, STICKY);
        checks++;
        if (st() !== e || dut_if.data_out !== 8'h01) begin
            failures++; $display("FAIL fill_pop1 got=%b/%h exp=%b/01", st(), dut_if.data_out, e);
        end
        cyc(0, 8'h00, 1);
        checks++;
        if (dut_if.data_out !== 8'h02) begin failures++; $display("FAIL fill_pop2 got=%h exp=02", dut_if.data_out); end
        cyc(1, 8'h55, 0);
        cyc(1, 8'h66, 0);
        e = mk(4, 0, STICKY);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL fill_refill got=%b exp=%b", st(), e); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 1);
            checks++;
            if (dut_if.data_out !== exp_w[i] || dut_if.valid_out !== 1'b1) begin
                failures++; $display("FAIL wrap_pop%0d got=%h v=%b exp=%h v=1", i, dut_if.data_out, dut_if.valid_out, exp_w[i]);
            end
        end
        e = mk(0, 1, STICKY);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL wrap_empty got=%b exp=%b", st(), e); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp_w [4];
        logic [8:0] e;
        exp_w[0] = 8'h22; exp_w[1] = 8'h33; exp_w[2] = 8'h44; exp_w[3] = 8'h77;
        apply_reset();
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
        cyc(1, 8'h77, 1);
        e = mk(4, 1, 0);
        checks++;
        if (st() !== e || dut_if.data_out !== 8'h11) begin
            failures++; $display("FAIL fullpp got=%b/%h exp=%b/11", st(), dut_if.data_out, e);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 1);
            checks++;
            if (dut_if.data_out !== exp_w[i]) begin failures++; $display("FAIL fullpp_pop%0d got=%h exp=%h", i, dut_if.data_out, exp_w[i]); end
        end
    endtask

    task automatic test_underflow();
        logic [8:0] e;
        apply_reset();
        cyc(0, 8'h00, 1);
        e = mk(0, 0, 1);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL udf_pop got=%b exp=%b", st(), e); end
        cyc(1, 8'h99, 1);
        e = mk(1, 0, 1);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL udf_pushpop got=%b exp=%b", st(), e); end
        cyc(0, 8'h00, 1);
        e = mk(0, 1, STICKY);
        checks++;
        if (st() !== e || dut_if.data_out !== 8'h99) begin
            failures++; $display("FAIL udf_next got=%b/%h exp=%b/99", st(), dut_if.data_out, e);
        end
    endtask

    task automatic test_error_mode();
        logic [8:0] e;
        apply_reset();
        cyc(1, 8'hD0, 0); cyc(1, 8'hD1, 0); cyc(1, 8'hD2, 0); cyc(1, 8'hD3, 0);
        cyc(1, 8'hDD, 0);
        e = mk(4, 0, 1);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL errmode_ovf got=%b exp=%b", st(), e); end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 8'h00, 0);
            e = mk(4, 0, STICKY);
            checks++;
            if (st() !== e) begin failures++; $display("FAIL errmode_idle%0d got=%b exp=%b", i, st(), e); end
        end
        cyc(0, 8'h00, 1);
        checks++;
        if (dut_if.data_out !== 8'hD0) begin failures++; $display("FAIL errmode_mem got=%h exp=d0", dut_if.data_out); end
        apply_reset();
        #1;
        e = mk(0, 0, 0);
        checks++;
        if (st() !== e) begin failures++; $display("FAIL errmode_reset got=%b exp=%b", st(), e); end
    endtask

    initial begin
        dut_if.push    = 1'b0;
        dut_if.pop     = 1'b0;
        dut_if.data_in = '0;
        test_reset();
        test_order();
        test_fill_wrap();
        test_full_pushpop();
        test_underflow();
        test_error_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_ochobits_cond.md
# fifo_ochobits_cond

Eight-bit synchronous FIFO that sits directly downstream of each output lane of the 1-to-2 eight-bit demux. It captures the lane's `valid`/data pair on push and delivers words in order on pop with a registered output. Occupancy and threshold flags let the consumer stage throttle the demux. One instance per demux output lane.

## Interface
- `DATA_WIDTH`, 8, word width; matches the demux lane width.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `ADDR_WIDTH`, 2, log2(`DEPTH`).
- `UMBRAL_ALTO`, 3, almost-full threshold; 1 ≤ value ≤ `DEPTH`.
- `UMBRAL_BAJO`, 1, almost-empty threshold; 0 ≤ value < `DEPTH`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `push` input 1: write strobe; driven by the demux `validoutN`.
- `data_in` input `DATA_WIDTH`: write data from the demux `dataout_*N`.
- `pop` input 1: read request from the consumer.
- `data_out` output `DATA_WIDTH`: registered read data.
- `valid_out` output 1: `data_out` is valid this cycle.
- `count` output `ADDR_WIDTH+1`: current occupancy, from 0 to `DEPTH`.
- `full` output 1: asserted when `count == DEPTH`.
- `empty` output 1: asserted when `count == 0`.
- `almost_full` output 1: asserted when `count >= UMBRAL_ALTO`.
- `almost_empty` output 1: asserted when `count <= UMBRAL_BAJO`.
- `error` output 1: overflow or underflow indication.

## Operation
- **Storage and pointers**
  - Storage is a `DEPTH`×`DATA_WIDTH` register array, with `wr_ptr` and `rd_ptr` of `ADDR_WIDTH` bits each.
  - Pointers wrap naturally from `DEPTH-1` to 0.
- **Push**
  - A push is accepted when `!full`, or when `full && pop` in the same cycle.
  - On accept: `mem[wr_ptr] <= data_in` and `wr_ptr` increments.
- **Pop**
  - A pop is accepted when `!empty`.
  - On accept: `data_out <= mem[rd_ptr]`, `valid_out <= 1`, and `rd_ptr` increments.
  - Otherwise `valid_out <= 0` and `data_out` holds its last value.
- **Count update**
  - +1 on an accepted push only.
  - −1 on an accepted pop only.
  - Unchanged when both or neither are accepted.
- **Simultaneous push and pop**
  - When not empty: both are accepted, so `count` is unchanged.
  - When empty: only the push is accepted. There is no fall-through bypass. The pop is an underflow.
- **Overflow**
  - `push && full && !pop` drops the word and raises `error`.
  - Pointers, `count` and memory are unchanged.
- **Underflow**
  - `pop && empty` raises `error`.
  - `valid_out` stays 0 and `rd_ptr` is unchanged.
- **Flags**
  - Flags are decoded combinationally from the registered `count` only, never from `push`/`pop`.
- **Reset** (`reset_L` low, asynchronous)
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `data_out` = 0, `valid_out` = 0, `error` = 0.
  - Hence `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored words immediately.
  - The first push is accepted on the first rising edge with `reset_L` high.

## Timing
- Write-to-readable latency is 1 cycle: a word pushed at edge N can be popped by a pop sampled at edge N+1.
- Read latency is 1 cycle: a pop sampled at edge N gives `data_out`/`valid_out` valid after edge N and held until edge N+1.
- Flags and `count` reflect operations sampled at edge N starting immediately after edge N.
- The producer must not push while `full` unless it also pops. The demux has no back-pressure, so the upstream controller gates `valid` on `almost_full`.

## Configuration
- The macro `FIFO_ERROR_STICKY_EN` selects the `error` behaviour.
- **Defined:** `error` is sticky. It is set on the first overflow or underflow and held until `reset_L` is asserted.
- **Undefined:** `error` is a one-cycle registered pulse, high in the cycle after each offending edge and cleared by the next edge with no fault.
- All other behaviour is identical in both builds.

## Test plan
1. **Reset:** assert `reset_L`=0 mid-burst → `count`=0, `empty`=1, `almost_empty`=1, `valid_out`=0, `data_out`=8'h00, `error`=0.
2. **Order and latency:** push 8'hA1, 8'hB2, 8'hC3 on consecutive edges, then pop 3 times → `data_out` gives A1, B2, C3 one cycle after each pop. `count` goes 1,2,3 then 2,1,0. `almost_full` is set at 3 and `almost_empty` at ≤1.
3. **Fill and wrap:** push 4 words → `full`=1. A fifth push without pop is dropped with `error`=1. Pop 2, push 8'h55, 8'h66, pop 4 → order is words 3, 4, 55, 66, which checks pointer wrap.
4. **Push and pop while full:** while `full`, push 8'h77 with pop → oldest word is output, `count` stays 4, `error` stays 0.
5. **Pop on empty:** pop alone on empty → `error`=1, `valid_out`=0. Push 8'h99 with pop on empty → `count`=1, `valid_out`=0. The next pop returns 8'h99.
6. **Error mode:** repeat the overflow with and without `FIFO_ERROR_STICKY_EN` → with the macro, `error` is held until reset; without it, `error` is a single-cycle pulse.
